nios_lcell_counter_chain: RTL and testbench



---
 rtl/nios_lcell_counter_chain_pkg.sv | 14 +
 rtl/nios_lcell_counter_chain_if.sv | 20 ++
 rtl/nios_lcell_counter_chain_count_step.sv | 33 +++
 rtl/nios_lcell_counter_chain.sv | 69 ++++++
 tb/tb_nios_lcell_counter_chain.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/nios_lcell_counter_chain_pkg.sv
// nios_lcell_pkg: shared constants and helpers for the lcell counter chain
//   MODE_COUNTER / MODE_NORMAL : OPERATION_MODE values
//   CNT_UP / CNT_DN            : updown encodings
//   clamp_to_max               : limit a value to the terminal count
package nios_lcell_pkg;
    localparam MODE_COUNTER = "counter";
    localparam MODE_NORMAL  = "normal";
    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;

    function automatic logic [32:0] clamp_to_max(input logic [32:0] v, input logic [32:0] m);
        return (v > m) ? m : v;
    endfunction
endpackage

// File: rtl/nios_lcell_counter_chain_if.sv
// nios_lcell_if: control/status bundle of one counter cell
//   master drives ena, sclr, sload, sload_data, updown, cin
//   slave (the cell) drives regout, cout, tc, ovf
interface nios_lcell_if #(parameter int WIDTH = 16);
    logic             ena;
    logic             sclr;
    logic             sload;
    logic [WIDTH-1:0] sload_data;
    logic             updown;
    logic             cin;
    logic [WIDTH-1:0] regout;
    logic             cout;
    logic             tc;
    logic             ovf;

    modport master (output ena, sclr, sload, sload_data, updown, cin,
                    input  regout, cout, tc, ovf);
    modport slave  (input  ena, sclr, sload, sload_data, updown, cin,
                    output regout, cout, tc, ovf);
endinterface

// File: rtl/nios_lcell_counter_chain_count_step.sv
// nios_lcell_count_step: combinational next count, terminal condition and cascade carry
//   regout   : current count
//   updown   : direction (CNT_UP / CNT_DN)
//   count_en : counting qualified this cycle
//   next_val : value after one count step (wrap or saturate applied)
//   term     : count sits at the limit for the current direction
//   cout     : count_en & term, feeds the next cell's cin
module nios_lcell_count_step
    import nios_lcell_pkg::*;
#(
    parameter int             WIDTH     = 16,
    parameter logic [WIDTH:0] MAX_COUNT = {1'b0, {WIDTH{1'b1}}},
    parameter bit             SATURATE  = 1'b0
) (
    input  logic [WIDTH-1:0] regout,
    input  logic             updown,
    input  logic             count_en,
    output logic [WIDTH-1:0] next_val,
    output logic             term,
    output logic             cout
);
    logic [WIDTH:0] cur;

    // One extra bit keeps the +1 at an all-ones MAX_COUNT from aliasing to zero in the compare
    always_comb begin
        cur      = {1'b0, regout};
        term     = (updown == CNT_UP) ? (cur == MAX_COUNT) : (cur == '0);
        next_val = (updown == CNT_UP)
                 ? (term ? (SATURATE ? regout : '0) : WIDTH'(cur + 1'b1))
                 : (term ? (SATURATE ? '0 : WIDTH'(MAX_COUNT)) : WIDTH'(cur - 1'b1));
        cout     = count_en & term;
    end
endmodule

// File: rtl/nios_lcell_counter_chain.sv
// nios_lcell_counter_chain: cascadable WIDTH-bit counter/register cell
//   clk, reset_n : clock and synchronous active-low reset
//   bus (slave)  : ena/sclr/sload/sload_data/updown/cin in; regout/cout/tc/ovf out
module nios_lcell_counter_chain
    import nios_lcell_pkg::*;
#(
    parameter int               WIDTH          = 16,
    parameter                   OPERATION_MODE = "counter",
    parameter logic [WIDTH:0]   MAX_COUNT      = {1'b0, {WIDTH{1'b1}}},
    parameter bit               SATURATE       = 1'b0,
    parameter logic [WIDTH-1:0] POWER_UP       = '0,
    parameter bit               CIN_USED       = 1'b0
) (
    input logic         clk,
    input logic         reset_n,
    nios_lcell_if.slave bus
);
    localparam bit IS_CNT = (OPERATION_MODE == MODE_COUNTER);

    logic [WIDTH-1:0] regout_d, regout_q, next_val, load_val;
    logic             tc_d, tc_q, ovf_d, ovf_q;
    logic             count_en, term, step_cout;

    nios_lcell_count_step #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT), .SATURATE(SATURATE)) u_step (
        .regout   (regout_q),
        .updown   (bus.updown),
        .count_en (count_en),
        .next_val (next_val),
        .term     (term),
        .cout     (step_cout)
    );

    always_comb begin
        count_en = bus.ena & (bus.cin | !CIN_USED) & ~bus.sclr & ~bus.sload;
        load_val = WIDTH'(clamp_to_max(33'(bus.sload_data), 33'(MAX_COUNT)));
        regout_d = regout_q;
        tc_d     = 1'b0;
        ovf_d    = ovf_q;
        if (bus.ena && bus.sclr) begin
            regout_d = '0;
            ovf_d    = 1'b0;
        end else if (!IS_CNT) begin
            regout_d = bus.ena ? load_val : regout_q;
        end else if (bus.ena && bus.sload) begin
            regout_d = load_val;
        end else if (count_en) begin
            regout_d = next_val;
            tc_d     = term;
            ovf_d    = ovf_q | term;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            regout_q <= POWER_UP;
            tc_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            regout_q <= regout_d;
            tc_q     <= tc_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.regout = regout_q;
    assign bus.cout   = IS_CNT & step_cout;
    assign bus.tc     = tc_q;
    assign bus.ovf    = ovf_q;
endmodule

// File: tb/tb_nios_lcell_counter_chain.sv
// tb_nios_lcell_counter_chain: directed checks of reset, wrap, saturate, priority, cascade and normal mode
module tb_nios_lcell_counter_chain;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nios_lcell_if #(.WIDTH(16)) b0 ();
    nios_lcell_if #(.WIDTH(4))  b1 ();
    nios_lcell_if #(.WIDTH(4))  b2 ();
    nios_lcell_if #(.WIDTH(4))  bl ();
    nios_lcell_if #(.WIDTH(4))  bh ();
    nios_lcell_if #(.WIDTH(4))  bn ();

    nios_lcell_counter_chain #(.WIDTH(16), .POWER_UP(16'd5)) u0 (.clk(clk), .reset_n(rst_n), .bus(b0));
    nios_lcell_counter_chain #(.WIDTH(4), .MAX_COUNT(5'd9)) u1 (.clk(clk), .reset_n(rst_n), .bus(b1));
    nios_lcell_counter_chain #(.WIDTH(4), .MAX_COUNT(5'd9), .SATURATE(1'b1)) u2 (.clk(clk), .reset_n(rst_n), .bus(b2));
    nios_lcell_counter_chain #(.WIDTH(4)) ul (.clk(clk), .reset_n(rst_n), .bus(bl));
    nios_lcell_counter_chain #(.WIDTH(4), .CIN_USED(1'b1)) uh (.clk(clk), .reset_n(rst_n), .bus(bh));
    nios_lcell_counter_chain #(.WIDTH(4), .OPERATION_MODE("normal")) un (.clk(clk), .reset_n(rst_n), .bus(bn));

    assign bh.cin = bl.cout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {b0.ena, b0.sclr, b0.sload, b0.updown, b0.cin} = '0; b0.sload_data = '0;
        {b1.ena, b1.sclr, b1.sload, b1.updown, b1.cin} = '0; b1.sload_data = '0;
        {b2.ena, b2.sclr, b2.sload, b2.updown, b2.cin} = '0; b2.sload_data = '0;
        {bl.ena, bl.sclr, bl.sload, bl.updown, bl.cin} = '0; bl.sload_data = '0;
        {bh.ena, bh.sclr, bh.sload, bh.updown} = '0;         bh.sload_data = '0;
        {bn.ena, bn.sclr, bn.sload, bn.updown, bn.cin} = '0; bn.sload_data = '0;

        // reset with ena low
        step();
        check("rst_regout", 32'(b0.regout), 32'd5);
        check("rst_tc", 32'(b0.tc), 32'd0);
        check("rst_ovf", 32'(b0.ovf), 32'd0);
        check("rst_u1", 32'(b1.regout), 32'd0);
        rst_n = 1'b1; b0.ena = 1'b1; b0.updown = 1'b1;
        for (int i = 6; i <= 8; i++) begin
            step();
            check("up_after_rst", 32'(b0.regout), 32'(i));
        end
        b0.ena = 1'b0;

        // wrap up at MAX_COUNT=9
        b1.ena = 1'b1; b1.sload = 1'b1; b1.sload_data = 4'd8;
        step();
        check("wrap_load", 32'(b1.regout), 32'd8);
        b1.sload = 1'b0; b1.updown = 1'b1;
        #1 check("wrap_cout8", 32'(b1.cout), 32'd0);
        step();
        check("wrap_9", 32'(b1.regout), 32'd9);
        check("wrap_cout9", 32'(b1.cout), 32'd1);
        check("wrap_tc9", 32'(b1.tc), 32'd0);
        step();
        check("wrap_0", 32'(b1.regout), 32'd0);
        check("wrap_tc0", 32'(b1.tc), 32'd1);
        check("wrap_ovf0", 32'(b1.ovf), 32'd1);
        check("wrap_cout0", 32'(b1.cout), 32'd0);
        step();
        check("wrap_1", 32'(b1.regout), 32'd1);
        check("wrap_tc1", 32'(b1.tc), 32'd0);
        check("wrap_ovf1", 32'(b1.ovf), 32'd1);

        // priority: sclr over sload, clamp on load, ena gating
        b1.sclr = 1'b1; b1.sload = 1'b1; b1.sload_data = 4'd7;
        step();
        check("prio_clr", 32'(b1.regout), 32'd0);
        check("prio_ovf", 32'(b1.ovf), 32'd0);
        b1.sclr = 1'b0; b1.sload_data = 4'd15;
        step();
        check("prio_clamp", 32'(b1.regout), 32'd9);
        b1.ena = 1'b0; b1.sclr = 1'b1; b1.sload = 1'b0;
        step();
        check("prio_ena0", 32'(b1.regout), 32'd9);
        b1.sclr = 1'b0;

        // saturate down
        b2.ena = 1'b1; b2.sload = 1'b1; b2.sload_data = 4'd1;
        step();
        check("sat_load", 32'(b2.regout), 32'd1);
        b2.sload = 1'b0; b2.updown = 1'b0;
        step();
        check("sat_r1", 32'(b2.regout), 32'd0);
        check("sat_tc1", 32'(b2.tc), 32'd0);
        step();
        check("sat_r2", 32'(b2.regout), 32'd0);
        check("sat_tc2", 32'(b2.tc), 32'd1);
        check("sat_ovf2", 32'(b2.ovf), 32'd1);
        step();
        check("sat_r3", 32'(b2.regout), 32'd0);
        check("sat_tc3", 32'(b2.tc), 32'd1);
        b2.sclr = 1'b1;
        step();
        check("sat_clr_r", 32'(b2.regout), 32'd0);
        check("sat_clr_ovf", 32'(b2.ovf), 32'd0);
        check("sat_clr_tc", 32'(b2.tc), 32'd0);
        b2.sclr = 1'b0; b2.ena = 1'b0;

        // cascade of two 4-bit cells
        bl.ena = 1'b1; bh.ena = 1'b1; bl.updown = 1'b1; bh.updown = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            check("casc", {24'd0, bh.regout, bl.regout}, 32'(i));
        end
        bl.ena = 1'b0; bh.ena = 1'b0;

        // normal mode register
        bn.ena = 1'b1; bn.sload_data = 4'hA; bn.updown = 1'b1;
        step();
        check("norm_load", 32'(bn.regout), 32'hA);
        check("norm_cout", 32'(bn.cout), 32'd0);
        bn.ena = 1'b0; bn.sload_data = 4'h3;
        step();
        check("norm_hold", 32'(bn.regout), 32'hA);
        bn.ena = 1'b1; bn.sclr = 1'b1;
        step();
        check("norm_clr", 32'(bn.regout), 32'd0);
        check("norm_tc", 32'(bn.tc), 32'd0);
        bn.ena = 1'b0; bn.sclr = 1'b0;

        // reset mid-count with sload asserted
        b0.ena = 1'b1; b0.sload = 1'b1; b0.sload_data = 16'hFFFF;
        step();
        b0.sload = 1'b0;
        step();
        check("mid_wrap", 32'(b0.regout), 32'd0);
        b0.sload = 1'b1; b0.sload_data = 16'h0120;
        step();
        b0.sload = 1'b0;
        step(); step(); step();
        check("mid_0123", 32'(b0.regout), 32'h0123);
        check("mid_ovf", 32'(b0.ovf), 32'd1);
        rst_n = 1'b0; b0.sload = 1'b1;
        step();
        check("mid_rst_r", 32'(b0.regout), 32'd5);
        check("mid_rst_ovf", 32'(b0.ovf), 32'd0);
        rst_n = 1'b1; b0.sload = 1'b0;
        step();
        check("mid_resume", 32'(b0.regout), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
